nco_tune_ctrl: RTL and testbench



---
 rtl/nco_tune_pkg.sv | 41 ++++
 rtl/nco_hex_entry.sv | 74 +++++++
 rtl/nco_tune_ctrl.sv | 145 ++++++++++++++
 tb/tb_nco_tune_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_tune_pkg.sv
// Shared command codes, preset multipliers and types for the NCO tuning controller.
package nco_tune_pkg;

  localparam logic [7:0] CMD_PRESET_1   = "a";
  localparam logic [7:0] CMD_PRESET_5   = "b";
  localparam logic [7:0] CMD_PRESET_10  = "f";
  localparam logic [7:0] CMD_PRESET_15  = "g";
  localparam logic [7:0] CMD_COARSE_DN  = "n";
  localparam logic [7:0] CMD_COARSE_UP  = "m";
  localparam logic [7:0] CMD_FINE_DN    = "o";
  localparam logic [7:0] CMD_FINE_UP    = "p";
  localparam logic [7:0] CMD_MUTE       = "z";
  localparam logic [7:0] CMD_LINK       = "l";
  localparam logic [7:0] CMD_HEX        = "x";
  localparam logic [7:0] CMD_DIGIT0     = "0";
  localparam logic [7:0] CMD_DIGIT9     = "9";

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  localparam logic [3:0] PRESET_MUL_1  = 4'd1;
  localparam logic [3:0] PRESET_MUL_5  = 4'd5;
  localparam logic [3:0] PRESET_MUL_10 = 4'd10;
  localparam logic [3:0] PRESET_MUL_15 = 4'd15;

  typedef enum logic {IDLE, HEX} hex_state_e;

  typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_ADD, OP_SUB} shadow_op_e;

  // Returns {is_hex_digit, nibble}; letters of either case map to 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= "0" && b <= "9")
      r = {1'b1, b[3:0]};
    else if ((b >= "a" && b <= "f") || (b >= "A" && b <= "F"))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/nco_hex_entry.sv
// HEX-entry sub-FSM: gathers up to PHASE_WIDTH/4 hex digits after 'x' and reports
// a clamped value on CR (done) or a one-cycle err on a malformed entry.
module nco_hex_entry
  import nco_tune_pkg::*;
#(
  parameter int PHASE_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  output logic                   busy,
  output logic                   done,
  output logic [PHASE_WIDTH-1:0] value,
  output logic                   err
);

  localparam int MAX_DIGITS = PHASE_WIDTH / 4;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam logic [PHASE_WIDTH-1:0] PHASE_MAX = {1'b0, {(PHASE_WIDTH-1){1'b1}}};

  hex_state_e             state;
  logic [PHASE_WIDTH-1:0] acc;
  logic [CNT_W-1:0]       n_digits;
  logic [4:0]             decoded;
  logic                   is_digit;
  logic                   is_cr;
  logic                   is_esc;
  logic                   full;
  logic                   empty;

  assign decoded  = hex_decode(rx_byte);
  assign is_digit = decoded[4];
  assign is_cr    = (rx_byte == ASCII_CR);
  assign is_esc   = (rx_byte == ASCII_ESC);
  assign full     = (n_digits == CNT_W'(MAX_DIGITS));
  assign empty    = (n_digits == '0);

  assign busy  = (state == HEX);
  assign done  = busy && rx_dv && is_cr && !empty;
  assign err   = busy && rx_dv && ((is_cr && empty) || (is_digit && full) ||
                                   (!is_digit && !is_cr && !is_esc));
  assign value = (acc > PHASE_MAX) ? PHASE_MAX : acc;

  // Every byte other than an accepted digit ends the entry; the parent decides
  // whether that exit was a write, an abort or an error.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      acc      <= '0;
      n_digits <= '0;
    end else if (rx_dv) begin
      case (state)
        IDLE: begin
          if (rx_byte == CMD_HEX) begin
            state    <= HEX;
            acc      <= '0;
            n_digits <= '0;
          end
        end
        HEX: begin
          if (is_digit && !full) begin
            acc      <= {acc[PHASE_WIDTH-5:0], decoded[3:0]};
            n_digits <= n_digits + CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nco_tune_ctrl.sv
// Multi-channel NCO tuning-word controller: decodes UART command bytes into saturated
// per-channel shadow increments that are committed together on apply_stb.
module nco_tune_ctrl
  import nco_tune_pkg::*;
#(
  parameter int PHASE_WIDTH = 64,
  parameter int NUM_CH = 2,
  parameter logic [PHASE_WIDTH-1:0] STEP_COARSE = 64'd196765270119568550,
  parameter logic [PHASE_WIDTH-1:0] STEP_FINE   = 64'd19676527011956855,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          rx_dv,
  input  logic [7:0]                    rx_byte,
  input  logic                          apply_stb,
  output logic [NUM_CH*PHASE_WIDTH-1:0] phase_inc,
  output logic [SEL_W-1:0]              sel_ch,
  output logic                          link,
  output logic                          hex_busy,
  output logic                          update_pend,
  output logic                          cmd_err
);

  localparam logic [PHASE_WIDTH-1:0] PHASE_MAX = {1'b0, {(PHASE_WIDTH-1){1'b1}}};
  localparam logic [7:0]             NUM_CH_B  = 8'(NUM_CH);

  shadow_op_e             op;
  logic [PHASE_WIDTH-1:0] op_val;
  logic                   hex_done;
  logic                   hex_err;
  logic [PHASE_WIDTH-1:0] hex_value;
  logic                   toggle_link;
  logic                   sel_wr;
  logic                   sel_err;
  logic [7:0]             digit;
  logic                   commit;

  function automatic logic [PHASE_WIDTH-1:0] preset_word(input logic [3:0] mult);
    logic [PHASE_WIDTH+3:0] prod;
    prod = {4'd0, STEP_COARSE} * {{PHASE_WIDTH{1'b0}}, mult};
    return (prod > {4'd0, PHASE_MAX}) ? PHASE_MAX : prod[PHASE_WIDTH-1:0];
  endfunction

  nco_hex_entry #(
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_hex (
    .clk     (clk),
    .arst_n  (arst_n),
    .rx_dv   (rx_dv),
    .rx_byte (rx_byte),
    .busy    (hex_busy),
    .done    (hex_done),
    .value   (hex_value),
    .err     (hex_err)
  );

  // Single-byte commands are only decoded outside hex entry; 'x' itself is
  // handled by the hex sub-module and so falls through as a no-op here.
  always_comb begin
    op          = OP_NONE;
    op_val      = '0;
    toggle_link = 1'b0;
    sel_wr      = 1'b0;
    sel_err     = 1'b0;
    digit       = rx_byte - CMD_DIGIT0;
    if (rx_dv && !hex_busy) begin
      case (rx_byte)
        CMD_PRESET_1:  begin op = OP_LOAD; op_val = preset_word(PRESET_MUL_1);  end
        CMD_PRESET_5:  begin op = OP_LOAD; op_val = preset_word(PRESET_MUL_5);  end
        CMD_PRESET_10: begin op = OP_LOAD; op_val = preset_word(PRESET_MUL_10); end
        CMD_PRESET_15: begin op = OP_LOAD; op_val = preset_word(PRESET_MUL_15); end
        CMD_COARSE_DN: begin op = OP_SUB;  op_val = STEP_COARSE; end
        CMD_COARSE_UP: begin op = OP_ADD;  op_val = STEP_COARSE; end
        CMD_FINE_DN:   begin op = OP_SUB;  op_val = STEP_FINE;   end
        CMD_FINE_UP:   begin op = OP_ADD;  op_val = STEP_FINE;   end
        CMD_MUTE:      begin op = OP_LOAD; op_val = '0;          end
        CMD_LINK:      toggle_link = 1'b1;
        default: begin
          if (rx_byte >= CMD_DIGIT0 && rx_byte <= CMD_DIGIT9) begin
            if (digit < NUM_CH_B) sel_wr  = 1'b1;
            else                  sel_err = 1'b1;
          end
        end
      endcase
    end else if (hex_done) begin
      op     = OP_LOAD;
      op_val = hex_value;
    end
  end

  assign commit = apply_stb && update_pend;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                   hit;
    logic [PHASE_WIDTH:0]   sum;
    logic [PHASE_WIDTH:0]   diff;
    logic [PHASE_WIDTH-1:0] nxt;
    logic [PHASE_WIDTH-1:0] shadow_q;
    logic [PHASE_WIDTH-1:0] commit_q;

    assign hit  = link || (sel_ch == SEL_W'(i));
    assign sum  = {1'b0, shadow_q} + {1'b0, op_val};
    assign diff = {1'b0, shadow_q} - {1'b0, op_val};

    always_comb begin
      nxt = shadow_q;
      case (op)
        OP_LOAD: nxt = op_val;
        OP_ADD:  nxt = (sum > {1'b0, PHASE_MAX}) ? PHASE_MAX : sum[PHASE_WIDTH-1:0];
        OP_SUB:  nxt = diff[PHASE_WIDTH] ? '0 : diff[PHASE_WIDTH-1:0];
        default: nxt = shadow_q;
      endcase
    end

    // The commit copies the shadow as it stood before this edge's write.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        shadow_q <= '0;
        commit_q <= '0;
      end else begin
        if (hit && (op != OP_NONE)) shadow_q <= nxt;
        if (commit)                 commit_q <= shadow_q;
      end
    end

    assign phase_inc[i*PHASE_WIDTH +: PHASE_WIDTH] = commit_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sel_ch      <= '0;
      link        <= 1'b0;
      update_pend <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      if (toggle_link) link   <= ~link;
      if (sel_wr)      sel_ch <= digit[SEL_W-1:0];
      cmd_err <= sel_err | hex_err;
      if (op != OP_NONE) update_pend <= 1'b1;
      else if (commit)   update_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Scoreboard bench for nco_tune_ctrl: directed command sequences plus random traffic,
// compared cycle by cycle against a behavioural model of the tuning rules.
module tb_nco_tune_ctrl;

  localparam int PW     = 64;
  localparam int NUM_CH = 2;
  localparam longint unsigned STEP_C = 64'd196765270119568550;
  localparam longint unsigned STEP_F = 64'd19676527011956855;
  localparam longint unsigned PMAX   = 64'h7FFF_FFFF_FFFF_FFFF;

  logic                 clk       = 1'b0;
  logic                 arst_n    = 1'b1;
  logic                 rx_dv     = 1'b0;
  logic [7:0]           rx_byte   = 8'h00;
  logic                 apply_stb = 1'b0;
  logic [NUM_CH*PW-1:0] phase_inc;
  logic [0:0]           sel_ch;
  logic                 link;
  logic                 hex_busy;
  logic                 update_pend;
  logic                 cmd_err;

  nco_tune_ctrl #(
    .PHASE_WIDTH (PW),
    .NUM_CH      (NUM_CH)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .apply_stb   (apply_stb),
    .phase_inc   (phase_inc),
    .sel_ch      (sel_ch),
    .link        (link),
    .hex_busy    (hex_busy),
    .update_pend (update_pend),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] phase;
    int           sel;
    bit           link;
    bit           busy;
    bit           pend;
    bit           err;
  } snap_t;

  snap_t sb[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  longint unsigned m_shadow [NUM_CH];
  longint unsigned m_commit [NUM_CH];
  int              m_sel;
  bit              m_link;
  bit              m_hex;
  bit              m_pend;
  bit              m_err;
  int              m_digits[$];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The monitor consumes one expected snapshot per observed cycle.
  always @(negedge clk) begin : monitor
    snap_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("phase_inc",   128'(phase_inc),   e.phase);
      checkOutput("sel_ch",      128'(sel_ch),      128'(e.sel));
      checkOutput("link",        128'(link),        128'(e.link));
      checkOutput("hex_busy",    128'(hex_busy),    128'(e.busy));
      checkOutput("update_pend", 128'(update_pend), 128'(e.pend));
      checkOutput("cmd_err",     128'(cmd_err),     128'(e.err));
    end
  end

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = 0;
      m_commit[i] = 0;
    end
    m_sel = 0; m_link = 0; m_hex = 0; m_pend = 0; m_err = 0;
    m_digits.delete();
  endfunction

  // kind: 0 = load, 1 = saturating add, 2 = saturating subtract
  function automatic void model_write(input int kind, input longint unsigned val);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_link || i == m_sel) begin
        if (kind == 0)      m_shadow[i] = val;
        else if (kind == 1) m_shadow[i] = (m_shadow[i] > PMAX - val) ? PMAX : m_shadow[i] + val;
        else                m_shadow[i] = (m_shadow[i] < val) ? 64'd0 : m_shadow[i] - val;
      end
    end
  endfunction

  function automatic longint unsigned preset(input longint unsigned mult);
    longint unsigned v;
    v = mult * STEP_C;
    return (v > PMAX) ? PMAX : v;
  endfunction

  function automatic void model_step(input bit dv, input logic [7:0] b, input bit stb);
    bit wr;
    int d;
    longint unsigned v;
    wr = 0;
    m_err = 0;
    if (stb && m_pend)
      for (int i = 0; i < NUM_CH; i++) m_commit[i] = m_shadow[i];
    if (dv && !m_hex) begin
      wr = 1;
      case (b)
        "a": model_write(0, preset(1));
        "b": model_write(0, preset(5));
        "f": model_write(0, preset(10));
        "g": model_write(0, preset(15));
        "n": model_write(2, STEP_C);
        "m": model_write(1, STEP_C);
        "o": model_write(2, STEP_F);
        "p": model_write(1, STEP_F);
        "z": model_write(0, 0);
        default: begin
          wr = 0;
          if (b == "l") m_link = !m_link;
          else if (b == "x") begin
            m_hex = 1;
            m_digits.delete();
          end else if (b >= "0" && b <= "9") begin
            if (int'(b) - 48 < NUM_CH) m_sel = int'(b) - 48;
            else m_err = 1;
          end
        end
      endcase
    end else if (dv) begin
      d = hex_val(b);
      if (d >= 0) begin
        if (m_digits.size() == PW / 4) begin
          m_err = 1;
          m_hex = 0;
        end else m_digits.push_back(d);
      end else if (b == 8'h0D) begin
        if (m_digits.size() == 0) m_err = 1;
        else begin
          v = 0;
          foreach (m_digits[k]) v = v * 64'd16 + 64'(m_digits[k]);
          model_write(0, (v > PMAX) ? PMAX : v);
          wr = 1;
        end
        m_hex = 0;
      end else begin
        if (b != 8'h1B) m_err = 1;
        m_hex = 0;
      end
    end
    m_pend = wr ? 1'b1 : (stb ? 1'b0 : m_pend);
  endfunction

  function automatic void push_snapshot();
    snap_t e;
    e.phase = {m_commit[1], m_commit[0]};
    e.sel   = m_sel;
    e.link  = m_link;
    e.busy  = m_hex;
    e.pend  = m_pend;
    e.err   = m_err;
    sb.push_back(e);
  endfunction

  task automatic applyStimulus(input bit dv, input logic [7:0] b, input bit stb);
    rx_dv     = dv;
    rx_byte   = dv ? b : 8'h00;
    apply_stb = stb;
    @(posedge clk);
    model_step(dv, b, stb);
    push_snapshot();
    @(negedge clk);
    #1;
    rx_dv     = 1'b0;
    apply_stb = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0);
  endtask

  task automatic strobe();
    applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  // Reset is asserted away from any clock edge so the clearing is seen before
  // the next posedge, then held across one edge.
  task automatic doReset();
    arst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_phase_inc",   128'(phase_inc),   128'd0);
    checkOutput("async_update_pend", 128'(update_pend), 128'd0);
    checkOutput("async_hex_busy",    128'(hex_busy),    128'd0);
    checkOutput("async_sel_link",    128'({sel_ch, link}), 128'd0);
    push_snapshot();
    @(negedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick_byte();
    string idle_pool;
    string hex_pool;
    int r;
    idle_pool = "abfgnmopzlx0123459q";
    hex_pool  = "0123456789abcdefABCDEF";
    r = int'($urandom_range(0, 99));
    if (m_hex) begin
      if (r < 80) return hex_pool[$urandom_range(0, 21)];
      if (r < 92) return 8'h0D;
      if (r < 96) return 8'h1B;
      return 8'($urandom_range(0, 255));
    end
    if (r < 85) return idle_pool[$urandom_range(0, idle_pool.len() - 1)];
    if (r < 90) return 8'h0D;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bit          dv;
    bit          stb;
    logic [7:0]  b;

    doReset();

    sendByte("a");
    strobe();
    checkOutput("preset_a_ch0", 128'(phase_inc[63:0]),   128'(STEP_C));
    checkOutput("preset_a_ch1", 128'(phase_inc[127:64]), 128'd0);
    checkOutput("pend_after_commit", 128'(update_pend), 128'd0);

    sendByte("g");
    for (int i = 0; i < 200; i++) sendByte("m");
    strobe();
    checkOutput("coarse_up_clamp", 128'(phase_inc[63:0]), 128'(PMAX));
    sendByte("z");
    sendByte("o");
    strobe();
    checkOutput("fine_down_floor", 128'(phase_inc[63:0]), 128'd0);

    sendByte("l");
    sendByte("f");
    strobe();
    checkOutput("linked_f_ch0", 128'(phase_inc[63:0]),   128'(STEP_C * 10));
    checkOutput("linked_f_ch1", 128'(phase_inc[127:64]), 128'(STEP_C * 10));
    sendByte("1");
    sendByte("l");
    sendByte("n");
    strobe();
    checkOutput("ch1_only_dec_ch0", 128'(phase_inc[63:0]),   128'(STEP_C * 10));
    checkOutput("ch1_only_dec_ch1", 128'(phase_inc[127:64]), 128'(STEP_C * 9));

    sendString("x1A2b");
    sendByte(8'h0D);
    strobe();
    checkOutput("hex_entry_ch1", 128'(phase_inc[127:64]), 128'h1A2B);

    sendByte("x");
    for (int i = 0; i < 17; i++) sendByte("7");
    checkOutput("hex_overflow_err", 128'(cmd_err), 128'd1);
    sendByte(8'h0D);
    sendString("xq");
    checkOutput("hex_bad_char_err", 128'(cmd_err), 128'd1);
    sendByte("x");
    sendByte(8'h1B);
    checkOutput("hex_esc_no_err", 128'({cmd_err, hex_busy}), 128'd0);

    strobe();
    applyStimulus(1'b1, "b", 1'b1);
    checkOutput("same_cycle_pend", 128'(update_pend), 128'd1);
    strobe();
    checkOutput("deferred_commit_b", 128'(phase_inc[127:64]), 128'(STEP_C * 5));
    sendByte("5");
    checkOutput("bad_channel_err", 128'(cmd_err), 128'd1);
    checkOutput("bad_channel_sel", 128'(sel_ch),  128'd1);

    sendByte("a");
    sendString("x123");
    doReset();
    sendByte(8'h0D);
    checkOutput("cr_after_reset_pend", 128'(update_pend), 128'd0);

    for (int n = 0; n < 2000; n++) begin
      dv  = ($urandom_range(0, 9) < 6);
      stb = ($urandom_range(0, 3) == 0);
      b   = pick_byte();
      if ($urandom_range(0, 399) == 0) doReset();
      else applyStimulus(dv, b, stb);
    end

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
